// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers, 32-cycle fixed latency.
// Define MUL_DIV_UNIT_SIGNED_EN to enable signed MULT/DIV (op[1]=1); otherwise op[1] is ignored.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divzero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        divzero_q, divzero_d;

    logic        is_div_in;
    logic [31:0] a_mag, b_mag;

    assign is_div_in = op[0];

`ifdef MUL_DIV_UNIT_SIGNED_EN
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;
    logic a_neg, b_neg;

    assign a_neg = op[1] & a[31];
    assign b_neg = op[1] & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;
`else
    logic unused_op1;

    assign unused_op1 = op[1];
    assign a_mag      = a;
    assign b_mag      = b;
`endif

    // One iteration step. Multiply keeps {partial product, multiplier}; divide keeps
    // {partial remainder, dividend/quotient}; opnd_q holds multiplicand or divisor.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    logic [63:0] step;

    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, work_q[31:1]};
        div_shift = {work_q[63:32], work_q[31]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[31:0] - opnd_q;
        div_next  = {(div_ge ? div_sub : div_shift[31:0]), work_q[30:0], div_ge};
        step      = is_div_q ? div_next : mul_next;
    end

    // Final result from the last step; sign correction only in the signed build.
    logic [31:0] res_hi, res_lo;

    always_comb begin
        res_hi = step[63:32];
        res_lo = step[31:0];
`ifdef MUL_DIV_UNIT_SIGNED_EN
        if (is_div_q) begin
            if (neg_res_q) res_lo = ~step[31:0] + 32'd1;
            if (neg_rem_q) res_hi = ~step[63:32] + 32'd1;
        end else if (neg_res_q) begin
            {res_hi, res_lo} = ~step + 64'd1;
        end
`endif
        // Divide by zero: remainder already equals the dividend, quotient is forced.
        if (dz_q) res_lo = 32'hFFFF_FFFF;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
`ifdef MUL_DIV_UNIT_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    cnt_d    = 5'd0;
                    is_div_d = is_div_in;
                    dz_d     = is_div_in & (b == 32'd0);
                    opnd_d   = is_div_in ? b_mag : a_mag;
                    work_d   = {32'd0, (is_div_in ? a_mag : b_mag)};
`ifdef MUL_DIV_UNIT_SIGNED_EN
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`endif
                end
            end
            StRun: begin
                work_d = step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d   = StDone;
                    hi_d      = res_hi;
                    lo_d      = res_lo;
                    divzero_d = dz_q;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            work_q    <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            divzero_q <= 1'b0;
`ifdef MUL_DIV_UNIT_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
`ifdef MUL_DIV_UNIT_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit plus hand sequences for ignored starts and
// mid-operation reset. Expected values for signed ops follow MUL_DIV_UNIT_SIGNED_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divzero (divzero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and check latency, busy, results and return to idle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int lat;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = y + 32'd1;
        lat   = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({name, " busy_first"}, {31'd0, busy}, 32'd1);
            if (done) lat = k;
        end
        check({name, " latency"}, lat, 32'd33);
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd1);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        check({name, " divzero"}, {31'd0, divzero}, {31'd0, exp_dz});
        @(negedge clk);
        check({name, " busy_after"}, {31'd0, busy}, 32'd0);
        check({name, " done_after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[2]  = '{2'b01, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0};
        vecs[4]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0};
        vecs[7]  = '{2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0};
        vecs[8]  = '{2'b01, 32'hDEAD_BEEF, 32'd16, 32'h0000_000F, 32'h0DEA_DBEE, 1'b0};
        vecs[9]  = '{2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
`ifdef MUL_DIV_UNIT_SIGNED_EN
        vecs[10] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[12] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
`else
        vecs[10] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
        vecs[12] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst divzero", {31'd0, divzero}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // MULTU 6*7 with DIVU starts during RUN cycle 5 and during DONE: both ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd6;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ndone      = 0;
        first_done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (k == 5 || done) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ign done_count", ndone, 32'd1);
        check("ign latency", first_done, 32'd33);
        check("ign lo", lo, 32'd42);
        check("ign hi", hi, 32'd0);
        check("ign busy", {31'd0, busy}, 32'd0);

        // Reset during RUN cycle 10 of MULTU 0x10000*0x10000.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort stays_idle", {31'd0, busy}, 32'd0);
        check("abort lo_held", lo, 32'd0);
        run_op("post_reset", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
